spike_rate_decoder: RTL and testbench

Receive-side counterpart of the LIF neuron array. Takes the per-neuron spike lines and converts them back to rate-coded values by counting spikes over a programmable time window. Completed windows are latched into a shadow bank and read out time-multiplexed over a single data bus. A valid/ack handshake and an overrun flag sit on that bus. The block sits between the neuron spike outputs and the chip's output pins or a host readout.

---
 rtl/spike_rate_decoder_if.sv | 27 ++
 rtl/spike_rate_decoder.sv | 143 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_if.sv
// Host-side readout bus of the spike rate decoder.
// Carries the channel select, the frame handshake and the status flags.
interface spike_rate_decoder_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [SW-1:0] rd_sel;
    logic          frame_ack;
    logic [CW-1:0] rate_out;
    logic          frame_valid;
    logic          overrun;
    logic          busy;

    // host side
    modport master (
        output rd_sel, frame_ack,
        input  rate_out, frame_valid, overrun, busy
    );

    // decoder side
    modport slave (
        input  rd_sel, frame_ack,
        output rate_out, frame_valid, overrun, busy
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a programmable window,
// latches completed windows into a shadow bank and exposes them through a
// time-multiplexed readout with a valid/ack handshake and an overrun flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no window running; waits for enable
// S_COUNT | window in progress; live counters accumulate spikes
module spike_rate_decoder #(
    parameter int NCH   = 4,
    parameter int CW    = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic [NCH-1:0]   spike_in,
    spike_rate_decoder_if.slave bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t           r_state;
    logic [WIN_W-1:0] r_len_q;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CW-1:0]    r_live   [NCH];
    logic [CW-1:0]    r_shadow [NCH];
    logic             r_frame_valid;
    logic             r_overrun;
    logic             r_busy;

    logic [WIN_W-1:0] w_len_eff;
    logic             w_last;
    logic [CW-1:0]    w_live_next [NCH];
    logic [CW-1:0]    w_rd_tbl [2**SW];

    // A zero window length is run as a single-cycle window.
    assign w_len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_last    = (r_win_cnt == r_len_q - 1'b1);

    // Saturating increment of each live counter by this cycle's spike.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_live_next[i] = r_live[i];
            if (spike_in[i] && (r_live[i] != '1)) begin
                w_live_next[i] = r_live[i] + 1'b1;
            end
        end
    end

    // Readout table padded to a power of two so out-of-range selects read 0.
    for (genvar g = 0; g < 2**SW; g++) begin : g_rd
        if (g < NCH) begin : g_ch
            assign w_rd_tbl[g] = r_shadow[g];
        end else begin : g_pad
            assign w_rd_tbl[g] = '0;
        end
    end

    assign bus.rate_out    = w_rd_tbl[bus.rd_sel];
    assign bus.frame_valid = r_frame_valid;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = r_busy;

    // Window sequencing FSM, counters, shadow bank and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len_q       <= '0;
            r_win_cnt     <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_live[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            // An ack retires the pending frame; a close in the same cycle
            // re-raises frame_valid below, so the new frame wins.
            if (bus.frame_ack && r_frame_valid) begin
                r_frame_valid <= 1'b0;
                r_overrun     <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state   <= S_COUNT;
                        r_busy    <= 1'b1;
                        r_len_q   <= w_len_eff;
                        r_win_cnt <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            r_live[i] <= '0;
                        end
                    end
                end

                S_COUNT: begin
                    if (w_last) begin
                        // Close: the last cycle's spikes are part of this frame,
                        // even if enable drops in that same cycle.
                        for (int i = 0; i < NCH; i++) begin
                            r_shadow[i] <= w_live_next[i];
                            r_live[i]   <= '0;
                        end
                        r_frame_valid <= 1'b1;
                        if (r_frame_valid && !bus.frame_ack) begin
                            r_overrun <= 1'b1;
                        end
                        r_win_cnt <= '0;
                        r_len_q   <= w_len_eff;
                        r_state   <= enable ? S_COUNT : S_IDLE;
                        r_busy    <= enable;
                    end else if (!enable) begin
                        // Abort: partial counts are discarded, no frame.
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_win_cnt <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            r_live[i] <= '0;
                        end
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        for (int i = 0; i < NCH; i++) begin
                            r_live[i] <= w_live_next[i];
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
`timescale 1ns/1ps
// Directed bench for spike_rate_decoder: an 8-bit-counter instance and a
// 4-bit-counter instance share the same stimulus.
module tb_spike_rate_decoder;
    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] win_len;
    logic [3:0] spike_in;

    int checks   = 0;
    int failures = 0;

    spike_rate_decoder_if #(.NCH(4), .CW(8)) bus8 ();
    spike_rate_decoder_if #(.NCH(4), .CW(4)) bus4 ();

    spike_rate_decoder #(.NCH(4), .CW(8), .WIN_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .win_len  (win_len),
        .spike_in (spike_in),
        .bus      (bus8)
    );

    spike_rate_decoder #(.NCH(4), .CW(4), .WIN_W(8)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .win_len  (win_len),
        .spike_in (spike_in),
        .bus      (bus4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] win;
        logic [3:0] spk;
        int         e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk_rates(input string nm, input int e0, input int e1,
                             input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            bus8.rd_sel = 2'(i);
            bus4.rd_sel = 2'(i);
            #1;
            chk($sformatf("%s_ch%0d", nm, i), int'(bus8.rate_out), e[i]);
            chk($sformatf("%s_sat_ch%0d", nm, i), int'(bus4.rate_out), sat4(e[i]));
        end
    endtask

    task automatic chk_flags(input string nm, input int fv, input int ov, input int bz);
        chk({nm, "_frame_valid"}, int'(bus8.frame_valid), fv);
        chk({nm, "_overrun"}, int'(bus8.overrun), ov);
        chk({nm, "_busy"}, int'(bus8.busy), bz);
        chk({nm, "_sat_frame_valid"}, int'(bus4.frame_valid), fv);
    endtask

    // One window from IDLE with a constant spike pattern, ending in IDLE.
    task automatic run_vec(input int idx, input bit do_ack);
        vec_t v;
        int   n;
        v = vecs[idx];
        n = (v.win == 8'd0) ? 1 : int'(v.win);
        win_len  = v.win;
        spike_in = v.spk;
        enable   = 1'b1;
        tick();
        chk($sformatf("vec%0d_busy_start", idx), int'(bus8.busy), 1);
        repeat (n - 1) tick();
        chk($sformatf("vec%0d_fv_early", idx), int'(bus8.frame_valid), 0);
        enable = 1'b0;
        tick();
        chk_flags($sformatf("vec%0d_close", idx), 1, 0, 0);
        chk_rates($sformatf("vec%0d", idx), v.e0, v.e1, v.e2, v.e3);
        if (do_ack) begin
            bus8.frame_ack = 1'b1;
            bus4.frame_ack = 1'b1;
            tick();
            bus8.frame_ack = 1'b0;
            bus4.frame_ack = 1'b0;
            chk($sformatf("vec%0d_fv_acked", idx), int'(bus8.frame_valid), 0);
        end
    endtask

    task automatic set_ack(input logic a);
        bus8.frame_ack = a;
        bus4.frame_ack = a;
    endtask

    initial begin
        logic [7:0] pat;

        vecs[0] = '{win: 8'd10, spk: 4'b0001, e0: 10, e1: 0, e2: 0, e3: 0};
        vecs[1] = '{win: 8'd5,  spk: 4'b1010, e0: 0,  e1: 5, e2: 0, e3: 5};
        vecs[2] = '{win: 8'd1,  spk: 4'b1111, e0: 1,  e1: 1, e2: 1, e3: 1};
        vecs[3] = '{win: 8'd0,  spk: 4'b0110, e0: 0,  e1: 1, e2: 1, e3: 0};
        vecs[4] = '{win: 8'd20, spk: 4'b1000, e0: 0,  e1: 0, e2: 0, e3: 20};
        vecs[5] = '{win: 8'd3,  spk: 4'b0101, e0: 3,  e1: 0, e2: 3, e3: 0};

        rst      = 1'b1;
        enable   = 1'b0;
        win_len  = 8'd10;
        spike_in = 4'b0000;
        set_ack(1'b0);
        bus8.rd_sel = 2'd0;
        bus4.rd_sel = 2'd0;
        repeat (2) tick();
        chk_flags("reset", 0, 0, 0);
        chk_rates("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Saturation: 255-cycle windows with every line high, back to back.
        win_len  = 8'd255;
        spike_in = 4'b1111;
        enable   = 1'b1;
        tick();
        repeat (254) tick();
        chk("sat_w1_fv_early", int'(bus8.frame_valid), 0);
        tick();
        chk_flags("sat_w1", 1, 0, 1);
        chk_rates("sat_w1", 255, 255, 255, 255);
        repeat (254) tick();
        enable = 1'b0;
        tick();
        chk_flags("sat_w2", 1, 1, 0);
        chk_rates("sat_w2", 255, 255, 255, 255);
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        chk_flags("sat_ack", 0, 0, 0);
        tick();

        // W1: ch1 pulses on window cycles 0, 3 and 7 of an 8-cycle window.
        win_len  = 8'd8;
        spike_in = 4'b0000;
        enable   = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            spike_in = (k == 0 || k == 3 || k == 7) ? 4'b0010 : 4'b0000;
            tick();
        end
        chk_flags("w1", 1, 0, 1);
        chk_rates("w1", 0, 3, 0, 0);

        // W2: back to back, no ack; ch2 high the whole window.
        spike_in = 4'b0100;
        repeat (7) tick();
        chk("w2_ov_early", int'(bus8.overrun), 0);
        chk_rates("w2_mid", 0, 3, 0, 0);
        tick();
        chk_flags("w2", 1, 1, 1);
        chk_rates("w2", 0, 0, 8, 0);

        // W3: new length requested mid-window; ack lands on the close edge.
        spike_in = 4'b1001;
        win_len  = 8'd10;
        for (int k = 0; k < 8; k++) begin
            set_ack(k == 7);
            tick();
        end
        set_ack(1'b0);
        chk_flags("w3_ack_on_close", 1, 0, 1);
        chk_rates("w3", 8, 0, 0, 8);

        // W4 (10 cycles): plain ack, then drop enable at window cycle 4.
        spike_in = 4'b0001;
        set_ack(1'b1);
        tick();
        set_ack(1'b0);
        chk_flags("w4_ack", 0, 0, 1);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        chk_flags("abort", 0, 0, 0);
        chk_rates("abort", 8, 0, 0, 8);
        repeat (12) tick();
        chk_flags("abort_idle", 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, i != 5);
        end

        // Asynchronous reset in the middle of a window.
        win_len  = 8'd10;
        spike_in = 4'b1111;
        enable   = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_flags("rst_mid", 0, 0, 0);
        chk_rates("rst_mid", 0, 0, 0, 0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // win_len = 0: every cycle closes a 1-cycle window.
        pat      = 8'b0010_1101;
        win_len  = 8'd0;
        spike_in = 4'b0000;
        enable   = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            spike_in = {3'b000, pat[k]};
            tick();
            chk($sformatf("w0_k%0d_fv", k), int'(bus8.frame_valid), 1);
            chk($sformatf("w0_k%0d_ov", k), int'(bus8.overrun), (k >= 1) ? 1 : 0);
            bus8.rd_sel = 2'd0;
            #1;
            chk($sformatf("w0_k%0d_ch0", k), int'(bus8.rate_out), int'(pat[k]));
        end
        enable = 1'b0;
        tick();
        chk("w0_idle_busy", int'(bus8.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
